// File: rtl/distribuidor_destino_if.sv
// Handshake and per-channel drain bundle between the upstream stream, the
// distributor and the four downstream consumers.
interface distribuidor_destino_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEST_W = 4,
  parameter int unsigned CNT_W  = 8
) ();
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic [DEST_W-1:0] dest_in;
  logic              ready_in;
  logic              pop0, pop1, pop2, pop3;
  logic [DATA_W-1:0] data_out0, data_out1, data_out2, data_out3;
  logic              empty0, empty1, empty2, empty3;
  logic              full0, full1, full2, full3;
  logic              err_dest;
  logic [CNT_W-1:0]  drop_cnt;

  modport master (
    output valid_in, data_in, dest_in, pop0, pop1, pop2, pop3,
    input  ready_in, data_out0, data_out1, data_out2, data_out3,
    input  empty0, empty1, empty2, empty3, full0, full1, full2, full3,
    input  err_dest, drop_cnt
  );

  modport slave (
    input  valid_in, data_in, dest_in, pop0, pop1, pop2, pop3,
    output ready_in, data_out0, data_out1, data_out2, data_out3,
    output empty0, empty1, empty2, empty3, full0, full1, full2, full3,
    output err_dest, drop_cnt
  );
endinterface

// File: rtl/distribuidor_destino.sv
// Egress distributor: steers a one-hot tagged word stream into four
// independent first-word-fall-through FIFOs, dropping illegally tagged words.
module distribuidor_destino #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEST_W = 4,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                   clk,
  input  logic                   reset_L,
  distribuidor_destino_if.slave  bus
);
  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = ADDR_W + 1;

  logic [DATA_W-1:0] mem_q [NCH][DEPTH];
  logic [DATA_W-1:0] mem_d [NCH][DEPTH];
  logic [ADDR_W-1:0] wr_q [NCH], wr_d [NCH];
  logic [ADDR_W-1:0] rd_q [NCH], rd_d [NCH];
  logic [CW-1:0]     count_q [NCH], count_d [NCH];
  logic [NCH-1:0]    empty_q, empty_d, full_q, full_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              legal_c, ready_c, accept_c;
  logic [NCH-1:0]    pop_req_c, push_c, pop_c;
  logic [DATA_W-1:0] dout_c [NCH];

  // Backpressure looks only at registered full flags: a same-cycle pop never frees a slot.
  always_comb begin
    legal_c   = $onehot(bus.dest_in);
    ready_c   = ~bus.valid_in | ~legal_c | ~(|(bus.dest_in[NCH-1:0] & full_q));
    accept_c  = bus.valid_in & ready_c;
    pop_req_c = {bus.pop3, bus.pop2, bus.pop1, bus.pop0};
    push_c    = (accept_c && legal_c) ? bus.dest_in[NCH-1:0] : '0;
    pop_c     = pop_req_c & ~empty_q;
  end

  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    empty_d = empty_q;
    full_d  = full_q;
    err_d   = bus.valid_in & ~legal_c;
    drop_d  = drop_q;
    for (int i = 0; i < NCH; i++) begin
      if (push_c[i]) begin
        mem_d[i][wr_q[i]] = bus.data_in;
        wr_d[i]           = wr_q[i] + ADDR_W'(1);
      end
      if (pop_c[i]) rd_d[i] = rd_q[i] + ADDR_W'(1);
      count_d[i] = count_q[i] + CW'(push_c[i]) - CW'(pop_c[i]);
      empty_d[i] = (count_d[i] == CW'(0));
      full_d[i]  = (count_d[i] == CW'(DEPTH));
    end
    if (err_d && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NCH; i++) begin
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
        wr_q[i]    <= '0;
        rd_q[i]    <= '0;
        count_q[i] <= '0;
      end
      empty_q <= '1;
      full_q  <= '0;
      err_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      err_q   <= err_d;
      drop_q  <= drop_d;
    end
  end

  // Head word is forced to zero whenever the channel is empty.
  always_comb begin
    for (int i = 0; i < NCH; i++) dout_c[i] = empty_q[i] ? '0 : mem_q[i][rd_q[i]];
  end

  assign bus.ready_in  = ready_c;
  assign bus.data_out0 = dout_c[0];
  assign bus.data_out1 = dout_c[1];
  assign bus.data_out2 = dout_c[2];
  assign bus.data_out3 = dout_c[3];
  assign bus.empty0    = empty_q[0];
  assign bus.empty1    = empty_q[1];
  assign bus.empty2    = empty_q[2];
  assign bus.empty3    = empty_q[3];
  assign bus.full0     = full_q[0];
  assign bus.full1     = full_q[1];
  assign bus.full2     = full_q[2];
  assign bus.full3     = full_q[3];
  assign bus.err_dest  = err_q;
  assign bus.drop_cnt  = drop_q;
endmodule
